period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter_pkg.sv | 14 +
 rtl/period_meter_sync_edge.sv | 32 +++
 rtl/period_meter.sv | 111 +++++++++++
 tb/tb_period_meter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// Shared types and default sizing for the period meter.
// Imported by the synchronizer/edge detector and the measurement core.
package period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS
    } state_t;

    localparam int DEF_WIDTH       = 28;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/period_meter_sync_edge.sv
// sig_in synchronizer followed by a registered dual-edge detector.
// A fill marker blocks edges until real samples reach the history stage.
module sync_edge
    import period_meter_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic edge_pulse
);

    localparam int N = STAGES + 2;

    // [STAGES-1:0] sync, [N-2] sample, [N-1] history
    logic [N-1:0] sh;
    logic [N-1:0] vp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh         <= '0;
            vp         <= '0;
            edge_pulse <= 1'b0;
        end else begin
            sh         <= {sh[N-2:0], d};
            vp         <= {vp[N-2:0], 1'b1};
            edge_pulse <= vp[N-1] & (sh[N-1] ^ sh[N-2]);
        end
    end

endmodule

// File: rtl/period_meter.sv
// Half-period meter: counts clk cycles between sig_in edges and
// hands each measurement to a consumer over a valid/ready pair.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             enable,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    input  logic             ready,
    output logic             timeout,
    output logic             overrun
);

    // Last count before the elapsed time (cnt+1) hits 2^WIDTH-1
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_n;
    logic             edge_pulse;
    logic             cap;
    logic             tmo;

    sync_edge #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (sig_in),
        .edge_pulse(edge_pulse)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cap     = 1'b0;
        tmo     = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = ARM;
                    cnt_n   = '0;
                end
                ARM: begin
                    cnt_n = '0;
                    if (edge_pulse) state_n = MEAS;
                end
                MEAS: begin
                    if (edge_pulse) begin
                        cap   = 1'b1;
                        cnt_n = '0;
                    end else if (cnt == CNT_LAST) begin
                        tmo     = 1'b1;
                        cnt_n   = '0;
                        state_n = ARM;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign timeout = tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // A capture may only replace result when the slot frees this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (!enable) overrun <= 1'b0;
            if (cap) begin
                if (!valid || ready) begin
                    result <= cnt + 1'b1;
                    valid  <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with a result scoreboard.
// Small WIDTH so the no-edge timeout is reachable quickly.
module tb_period_meter;
    import period_meter_pkg::*;

    localparam int W = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sig_in;
    logic         enable;
    logic         ready;
    logic [W-1:0] result;
    logic         valid;
    logic         timeout;
    logic         overrun;

    int asserts = 0;
    int fails   = 0;
    int tmo_cnt = 0;
    int exp_q[$];
    int e;

    period_meter #(
        .WIDTH      (W),
        .SYNC_STAGES(S)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .enable (enable),
        .result (result),
        .valid  (valid),
        .ready  (ready),
        .timeout(timeout),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        asserts++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tog();
        sig_in = ~sig_in;
    endtask

    task automatic edge_lat(output int m);
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (!dut.edge_pulse && m < 20);
    endtask

    // Monitor: every accepted result is matched against the queue
    always @(negedge clk) begin
        #1;
        if (rst_n && valid && ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", int'(result), -1);
            end else begin
                e = exp_q.pop_front();
                chk("result", int'(result), e);
            end
        end
        if (timeout) tmo_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int m;
        int n;
        int t0;
        int ec;
        int vc;
        rst_n  = 1'b0;
        enable = 1'b0;
        ready  = 1'b0;
        sig_in = 1'b0;
        #1;
        chk("rst_result", int'(result), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_overrun", int'(overrun), 0);
        wait_n(3);
        rst_n = 1'b1;
        wait_n(2);

        // steady half-period 5, ready always high
        t0 = tmo_cnt;
        enable = 1'b1;
        ready  = 1'b1;
        wait_n(2);
        tog();
        wait_n(5);
        for (int i = 0; i < 5; i++) begin
            tog();
            exp_q.push_back(5);
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                if (i == 0 && k == 3)
                    chk("edge_early", int'(dut.edge_pulse), 0);
                if (i == 0 && k == 4) begin
                    chk("edge_lat", int'(dut.edge_pulse), 1);
                    chk("valid_before", int'(valid), 0);
                end
                if (i == 0 && k == 5)
                    chk("valid_after_edge", int'(valid), 1);
            end
        end
        wait_n(2);
        chk("steady_q_empty", exp_q.size(), 0);
        chk("steady_no_tmo", tmo_cnt - t0, 0);
        enable = 1'b0;
        wait_n(2);

        // back-pressure, half-period 8
        enable = 1'b1;
        ready  = 1'b0;
        wait_n(2);
        tog();
        wait_n(8);
        tog();
        exp_q.push_back(8);
        wait_n(8);
        chk("bp_valid1", int'(valid), 1);
        chk("bp_ovr_before", int'(overrun), 0);
        tog();
        wait_n(6);
        chk("bp_result_held", int'(result), 8);
        chk("bp_valid2", int'(valid), 1);
        chk("bp_overrun", int'(overrun), 1);
        ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_clr", int'(valid), 0);
        chk("bp_ovr_sticky", int'(overrun), 1);
        enable = 1'b0;
        @(negedge clk);
        chk("bp_ovr_clr", int'(overrun), 0);
        wait_n(1);

        // timeout after a single arming edge
        t0 = tmo_cnt;
        enable = 1'b1;
        ready  = 1'b1;
        wait_n(2);
        tog();
        edge_lat(m);
        chk("arm_edge_lat", m, S + 2);
        n = 0;
        while (!timeout && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_delay", n, 15);
        wait_n(20);
        chk("tmo_once", tmo_cnt - t0, 1);
        chk("tmo_state_arm", int'(dut.state), int'(ARM));
        chk("tmo_valid", int'(valid), 0);
        enable = 1'b0;
        wait_n(2);

        // capture coinciding with a handshake
        enable = 1'b1;
        ready  = 1'b0;
        wait_n(2);
        tog();
        wait_n(5);
        tog();
        exp_q.push_back(5);
        wait_n(3);
        tog();
        exp_q.push_back(3);
        wait_n(4);
        chk("co_edge", int'(dut.edge_pulse), 1);
        chk("co_valid_pre", int'(valid), 1);
        chk("co_result_pre", int'(result), 5);
        ready = 1'b1;
        @(negedge clk);
        chk("co_valid_kept", int'(valid), 1);
        chk("co_result_new", int'(result), 3);
        chk("co_no_ovr", int'(overrun), 0);
        @(negedge clk);
        chk("co_valid_clr", int'(valid), 0);
        enable = 1'b0;
        wait_n(2);

        // reset mid-measurement with a pending result
        enable = 1'b1;
        ready  = 1'b0;
        wait_n(2);
        tog();
        wait_n(5);
        tog();
        wait_n(6);
        chk("mr_pending", int'(valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mr_result", int'(result), 0);
        chk("mr_valid", int'(valid), 0);
        chk("mr_overrun", int'(overrun), 0);
        chk("mr_timeout", int'(timeout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        ec = 0;
        vc = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (dut.edge_pulse) ec++;
            if (valid) vc++;
        end
        chk("mr_no_edge", ec, 0);
        chk("mr_no_valid", vc, 0);
        tog();
        edge_lat(m);
        chk("mr_edge_lat", m, S + 2);
        @(negedge clk);
        tog();
        exp_q.push_back(5);
        wait_n(7);
        chk("mr_q_empty", exp_q.size(), 0);
        enable = 1'b0;
        wait_n(2);

        chk("final_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end

endmodule
